// File: rtl/booth_pkg.sv
// Shared types for the radix-2 Booth multiplier: FSM states and the
// per-iteration recoding of {Q[0], Q-1} into NOP / ADD / SUB.
package booth_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   typedef enum logic [1:0] {
      OP_NOP,
      OP_ADD,
      OP_SUB
   } booth_op_t;

   function automatic booth_op_t booth_recode(input logic q0, input logic q_m1);
      case ({q0, q_m1})
         2'b01:   return OP_ADD;
         2'b10:   return OP_SUB;
         default: return OP_NOP;
      endcase
   endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: add/subtract M into A per the recoding,
// then arithmetic-shift {A, Q, Q-1} right by one. No state, no flow control.
module booth_step
   import booth_pkg::*;
#(
   parameter int W = 8
) (
   input  logic [W:0]   a,
   input  logic [W-1:0] q,
   input  logic         q_m1,
   input  logic [W:0]   m,
   output logic [W:0]   a_out,
   output logic [W-1:0] q_out,
   output logic         q_m1_out
);

   logic [W:0] sum;

   always_comb begin
      case (booth_recode(q[0], q_m1))
         OP_ADD:  sum = a + m;
         OP_SUB:  sum = a - m;
         default: sum = a;
      endcase
      // sum[W] is the guard/sign bit, replicated into the vacated MSB
      {a_out, q_out, q_m1_out} = {sum[W], sum, q};
   end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed radix-2 Booth multiplier, one iteration per cycle.
// Result Operand_Width edges after Start is accepted; Start is ignored while busy or in DONE.
module booth_multiplier
   import booth_pkg::*;
#(
   parameter int Operand_Width = 8,
   parameter int Product_Width = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     Start,
   input  logic [Operand_Width-1:0] Multiplicand,
   input  logic [Operand_Width-1:0] Multiplier,
   output logic [Product_Width-1:0] Product,
   output logic                     Busy,
   output logic                     Done
);

   localparam int W  = Operand_Width;
   localparam int CW = $clog2(W + 1);

   generate
      if (Product_Width != 2 * Operand_Width) begin : g_width_check
         $error("booth_multiplier: Product_Width must equal 2*Operand_Width");
      end
   endgenerate

   state_t          state, state_nxt;
   logic [W:0]      m_r, a_r, a_nxt;
   logic [W-1:0]    q_r, q_nxt;
   logic            qm1_r, qm1_nxt;
   logic [CW-1:0]   count_r;
   logic            last_iter;
   logic            accept;

   booth_step #(.W(W)) u_step (
      .a        (a_r),
      .q        (q_r),
      .q_m1     (qm1_r),
      .m        (m_r),
      .a_out    (a_nxt),
      .q_out    (q_nxt),
      .q_m1_out (qm1_nxt)
   );

   assign last_iter = (count_r == CW'(1));
   assign accept    = (state == IDLE) && Start;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (Start) state_nxt = RUN;
         RUN:     if (last_iter) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         m_r     <= '0;
         a_r     <= '0;
         q_r     <= '0;
         qm1_r   <= 1'b0;
         count_r <= '0;
         Product <= '0;
         Busy    <= 1'b0;
         Done    <= 1'b0;
      end else begin
         state <= state_nxt;
         // Flags follow the next state so they are flops, not state decodes
         Busy  <= (state_nxt == RUN);
         Done  <= (state_nxt == DONE);
         if (accept) begin
            m_r     <= {Multiplicand[W-1], Multiplicand};
            a_r     <= '0;
            q_r     <= Multiplier;
            qm1_r   <= 1'b0;
            count_r <= CW'(W);
         end else if (state == RUN) begin
            a_r     <= a_nxt;
            q_r     <= q_nxt;
            qm1_r   <= qm1_nxt;
            count_r <= count_r - CW'(1);
            if (last_iter) Product <= {a_nxt[W-1:0], q_nxt};
         end
      end
   end

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed-vector bench for booth_multiplier with hand-computed products.
module tb_booth_multiplier;

   localparam int W = 8;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          Start = 1'b0;
   logic [W-1:0]  Multiplicand = '0;
   logic [W-1:0]  Multiplier = '0;
   logic [2*W-1:0] Product;
   logic          Busy;
   logic          Done;

   int n_cmp = 0;
   int n_err = 0;

   booth_multiplier #(.Operand_Width(W), .Product_Width(2*W)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .Start        (Start),
      .Multiplicand (Multiplicand),
      .Multiplier   (Multiplier),
      .Product      (Product),
      .Busy         (Busy),
      .Done         (Done)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST   = 1'b1;
      Start = 1'b0;
      tick();
      tick();
      chk("rst_product", 32'(Product), 32'h0);
      chk("rst_busy", 32'(Busy), 32'h0);
      chk("rst_done", 32'(Done), 32'h0);
      RST = 1'b0;
   endtask

   // Accept one multiplication, scramble operands afterwards, and check
   // the single Done pulse lands W edges after the accepting edge.
   task automatic run_mul(input string tag, input logic [W-1:0] m, input logic [W-1:0] q,
                          input logic [2*W-1:0] exp);
      int ndone = 0;
      int pos = -1;
      logic [2*W-1:0] res = '0;
      Multiplicand = m;
      Multiplier   = q;
      Start        = 1'b1;
      tick();
      Start        = 1'b0;
      Multiplicand = ~m;
      Multiplier   = q ^ 8'h5A;
      chk({tag, "_busy"}, 32'(Busy), 32'h1);
      for (int i = 1; i <= W + 3; i++) begin
         tick();
         if (Done) begin
            ndone++;
            if (pos < 0) begin
               pos = i;
               res = Product;
               chk({tag, "_busy_at_done"}, 32'(Busy), 32'h0);
            end
         end
      end
      chk({tag, "_product"}, 32'(res), 32'(exp));
      chk({tag, "_npulse"}, 32'(ndone), 32'd1);
      chk({tag, "_latency"}, 32'(pos), 32'(W));
      chk({tag, "_hold"}, 32'(Product), 32'(exp));
   endtask

   initial begin : main
      int pos1, pos2, ndone, seen_done;
      logic [2*W-1:0] r1, r2;

      do_reset();
      run_mul("b1", 8'h1B, 8'h78, 16'h0CA8);
      do_reset();
      run_mul("b2", 8'hAD, 8'h3E, 16'hEBE6);
      do_reset();
      run_mul("b3", 8'hCC, 8'hCC, 16'h0A90);
      do_reset();
      run_mul("x1", 8'h7F, 8'h80, 16'hC080);
      do_reset();
      run_mul("x2", 8'h80, 8'h80, 16'h4000);
      do_reset();
      run_mul("x3", 8'h70, 8'hFE, 16'hFF20);
      do_reset();
      run_mul("sw0", 8'hCC, 8'hCC, 16'h0A90);
      do_reset();
      run_mul("sw1", 8'hCC, 8'hCD, 16'h0A5C);
      do_reset();
      run_mul("sw2", 8'hCC, 8'hCE, 16'h0A28);
      do_reset();
      run_mul("sw3", 8'hCC, 8'hCF, 16'h09F4);

      // Start pulsed mid-RUN with different operands must be ignored
      do_reset();
      Multiplicand = 8'h1B;
      Multiplier   = 8'h78;
      Start        = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      tick();
      Multiplicand = 8'h80;
      Multiplier   = 8'h80;
      Start        = 1'b1;
      tick();
      Start = 1'b0;
      chk("sb_busy", 32'(Busy), 32'h1);
      ndone = 0;
      pos1  = -1;
      r1    = '0;
      for (int i = 4; i <= W + 3; i++) begin
         tick();
         if (Done) begin
            ndone++;
            if (pos1 < 0) begin
               pos1 = i;
               r1   = Product;
            end
         end
      end
      chk("sb_product", 32'(r1), 32'h0CA8);
      chk("sb_latency", 32'(pos1), 32'(W));
      chk("sb_npulse", 32'(ndone), 32'd1);

      // Reset after the third iteration aborts with no Done
      do_reset();
      Multiplicand = 8'h1B;
      Multiplier   = 8'h78;
      Start        = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      tick();
      tick();
      RST = 1'b1;
      tick();
      chk("mr_product", 32'(Product), 32'h0);
      chk("mr_busy", 32'(Busy), 32'h0);
      chk("mr_done", 32'(Done), 32'h0);
      RST = 1'b0;
      seen_done = 0;
      for (int i = 0; i < W + 4; i++) begin
         tick();
         if (Done) seen_done++;
      end
      chk("mr_no_done", 32'(seen_done), 32'd0);
      run_mul("mr_next", 8'h4E, 8'h2B, 16'h0D1A);

      // Start held high: back-to-back results W+2 edges apart
      do_reset();
      Multiplicand = 8'hCC;
      Multiplier   = 8'hCD;
      Start        = 1'b1;
      tick();
      Multiplicand = 8'h4E;
      Multiplier   = 8'h2B;
      pos1 = -1;
      pos2 = -1;
      r1   = '0;
      r2   = '0;
      for (int i = 1; i <= 2 * W + 4; i++) begin
         tick();
         if (Done) begin
            if (pos1 < 0) begin
               pos1 = i;
               r1   = Product;
            end else if (pos2 < 0) begin
               pos2 = i;
               r2   = Product;
            end
         end
      end
      Start = 1'b0;
      chk("bb_first", 32'(r1), 32'h0A5C);
      chk("bb_second", 32'(r2), 32'h0D1A);
      chk("bb_pos1", 32'(pos1), 32'(W));
      chk("bb_spacing", 32'(pos2 - pos1), 32'(W + 2));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
